// File: rtl/ysyx_041514_lsu_mem_stage.sv
// ysyx_041514_lsu_mem_stage: memory-access stage issuing one aligned 64-bit request per load/store.
// Misaligned accesses are flagged in IDLE instead of being issued.
module ysyx_041514_lsu_mem_stage #(
  parameter int XLEN = 64,
  parameter int MEMOP_LEN = 4,
  parameter int REGIDX_LEN = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid_i,
  input  logic [MEMOP_LEN-1:0]  mem_op_i,
  input  logic [XLEN-1:0]       addr_i,
  input  logic [XLEN-1:0]       store_data_i,
  input  logic [REGIDX_LEN-1:0] rd_idx_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [XLEN-1:0]       mem_req_addr_o,
  output logic                  mem_req_we_o,
  output logic [7:0]            mem_req_wstrb_o,
  output logic [XLEN-1:0]       mem_req_wdata_o,
  input  logic                  mem_resp_valid_i,
  input  logic [XLEN-1:0]       mem_resp_data_i,
  output logic [XLEN-1:0]       load_data_o,
  output logic                  load_valid_o,
  output logic [REGIDX_LEN-1:0] rd_idx_o,
  output logic                  lsu_stall_req_o,
  output logic                  misalign_load_o,
  output logic                  misalign_store_o
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  state_t state, nxt;
  logic [MEMOP_LEN-1:0] op_q;
  logic [XLEN-1:0] addr_q, data_q, sh, ext;
  logic [1:0] lg_i, lg_q;
  logic [7:0] mask;
  logic ld_i, st_i, ld_q, st_q, mis, start, req, sgn;
  // log2 of access size: loads 1..7 map onto 0..3 via op-1 on the low two bits
  assign lg_i = mem_op_i[3] ? mem_op_i[1:0] : mem_op_i[1:0] - 2'd1;
  assign lg_q = op_q[3] ? op_q[1:0] : op_q[1:0] - 2'd1;
  assign ld_i = (mem_op_i != '0) & ~mem_op_i[3];
  assign st_i = mem_op_i[3:2] == 2'b10;
  assign ld_q = (op_q != '0) & ~op_q[3];
  assign st_q = op_q[3:2] == 2'b10;
  assign mis = (lg_i == 2'd1 & addr_i[0]) | (lg_i == 2'd2 & |addr_i[1:0]) |
               (lg_i == 2'd3 & |addr_i[2:0]);
  assign start = state == S_IDLE & ex_valid_i & (ld_i | st_i) & ~mis;
  assign misalign_load_o = state == S_IDLE & ex_valid_i & ld_i & mis;
  assign misalign_store_o = state == S_IDLE & ex_valid_i & st_i & mis;
  assign req = state == S_REQ;
  assign mask = lg_q == 2'd0 ? 8'h01 : lg_q == 2'd1 ? 8'h03 : lg_q == 2'd2 ? 8'h0f : 8'hff;
  assign mem_req_valid_o = req;
  assign mem_req_addr_o = req ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign mem_req_we_o = req & st_q;
  assign mem_req_wstrb_o = req & st_q ? mask << addr_q[2:0] : 8'h00;
  assign mem_req_wdata_o = req & st_q ? data_q << {addr_q[2:0], 3'b000} : '0;
  assign lsu_stall_req_o = start | req | state == S_WAIT;
  assign load_valid_o = state == S_DONE & ld_q;
  // LB/LH/LW (1..3) sign-extend; LBU/LHU/LWU (5..7) zero-extend; LD needs none
  assign sgn = ~op_q[2];
  assign sh = mem_resp_data_i >> {addr_q[2:0], 3'b000};
  assign ext = lg_q == 2'd0 ? {{(XLEN-8){sgn & sh[7]}}, sh[7:0]} :
               lg_q == 2'd1 ? {{(XLEN-16){sgn & sh[15]}}, sh[15:0]} :
               lg_q == 2'd2 ? {{(XLEN-32){sgn & sh[31]}}, sh[31:0]} : sh;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: nxt = start ? S_REQ : S_IDLE;
      S_REQ:  nxt = mem_req_ready_i ? (st_q ? S_DONE : S_WAIT) : S_REQ;
      S_WAIT: nxt = mem_resp_valid_i ? S_DONE : S_WAIT;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      rd_idx_o <= '0;
      load_data_o <= '0;
    end else begin
      state <= nxt;
      if (start) begin
        op_q <= mem_op_i;
        addr_q <= addr_i;
        data_q <= store_data_i;
        rd_idx_o <= rd_idx_i;
      end
      if (state == S_WAIT && mem_resp_valid_i) load_data_o <= ext;
    end
  end
endmodule

// File: tb/tb_ysyx_041514_lsu_mem_stage.sv
// tb_ysyx_041514_lsu_mem_stage: randomized transactions checked every cycle against a
// transaction-level model of the memory stage, plus literal spot checks.
module tb_ysyx_041514_lsu_mem_stage;
  logic clk = 0, rst = 1;
  logic ex_valid = 0, ready = 0, resp_valid = 0;
  logic [3:0] mem_op = 0;
  logic [63:0] addr = 0, sdata = 0, resp_data = 0;
  logic [4:0] rd_idx = 0;
  logic req_valid, req_we, load_valid, stall, mis_ld, mis_st;
  logic [63:0] req_addr, req_wdata, load_data;
  logic [7:0] req_wstrb;
  logic [4:0] rd_out;
  int errors = 0, checks = 0;
  logic chk_en = 0;
  logic exp_valid = 0, exp_we = 0, exp_stall = 0, exp_lv = 0, exp_ml = 0, exp_ms = 0;
  logic [63:0] exp_addr = 0, exp_wdata = 0, exp_ld = 0;
  logic [7:0] exp_wstrb = 0;
  logic [4:0] exp_rd = 0;
  logic [63:0] cap_addr, cap_wdata, cap_ld;
  logic [7:0] cap_wstrb;
  logic cap_we, cap_lv;
  logic [63:0] got;

  ysyx_041514_lsu_mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid), .mem_op_i(mem_op), .addr_i(addr),
    .store_data_i(sdata), .rd_idx_i(rd_idx), .mem_req_valid_o(req_valid),
    .mem_req_ready_i(ready), .mem_req_addr_o(req_addr), .mem_req_we_o(req_we),
    .mem_req_wstrb_o(req_wstrb), .mem_req_wdata_o(req_wdata),
    .mem_resp_valid_i(resp_valid), .mem_resp_data_i(resp_data), .load_data_o(load_data),
    .load_valid_o(load_valid), .rd_idx_o(rd_out), .lsu_stall_req_o(stall),
    .misalign_load_o(mis_ld), .misalign_store_o(mis_st)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void chk(string n, logic [63:0] act, logic [63:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, e);
    end
  endfunction

  function automatic int nbytes(logic [3:0] op);
    return (op == 1 || op == 5 || op == 8) ? 1 : (op == 2 || op == 6 || op == 9) ? 2 :
           (op == 3 || op == 7 || op == 10) ? 4 : 8;
  endfunction

  function automatic bit is_ld(logic [3:0] op);
    return op >= 1 && op <= 7;
  endfunction

  function automatic bit is_st(logic [3:0] op);
    return op >= 8 && op <= 11;
  endfunction

  function automatic logic [63:0] mload(logic [3:0] op, logic [63:0] a, logic [63:0] r);
    int nb = nbytes(op);
    logic [63:0] v = r >> (8 * int'(a[2:0]));
    logic [63:0] m;
    if (nb < 8) begin
      m = (64'd1 << (8 * nb)) - 64'd1;
      v = v & m;
      if (op <= 3 && v[8*nb-1]) v = v | ~m;
    end
    return v;
  endfunction

  always @(negedge clk) if (chk_en) begin
    chk("req_valid", 64'(req_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("req_addr", req_addr, exp_addr);
      chk("req_we", 64'(req_we), 64'(exp_we));
      chk("req_wstrb", 64'(req_wstrb), 64'(exp_wstrb));
      if (exp_we) chk("req_wdata", req_wdata, exp_wdata);
    end
    chk("stall", 64'(stall), 64'(exp_stall));
    chk("load_valid", 64'(load_valid), 64'(exp_lv));
    if (exp_lv) begin
      chk("load_data", load_data, exp_ld);
      chk("rd_idx", 64'(rd_out), 64'(exp_rd));
    end
    chk("misalign_load", 64'(mis_ld), 64'(exp_ml));
    chk("misalign_store", 64'(mis_st), 64'(exp_ms));
  end

  task automatic scramble();
    ex_valid = 1'($urandom);
    mem_op = 4'($urandom);
    addr = {$urandom, $urandom};
    sdata = {$urandom, $urandom};
    rd_idx = 5'($urandom);
  endtask

  task automatic xact(input logic [3:0] op, input logic [63:0] a, input logic [63:0] d,
                      input logic [4:0] rd, input int rdel, input int wdel,
                      input logic [63:0] r);
    int nb = nbytes(op);
    ex_valid = 1; mem_op = op; addr = a; sdata = d; rd_idx = rd;
    exp_valid = 0; exp_stall = 1; exp_lv = 0; exp_ml = 0; exp_ms = 0;
    @(posedge clk); #1;
    scramble();
    exp_valid = 1;
    exp_addr = a & ~64'h7;
    exp_we = is_st(op);
    exp_wstrb = is_st(op) ? 8'(((1 << nb) - 1) << a[2:0]) : 8'h00;
    exp_wdata = d << (8 * int'(a[2:0]));
    for (int i = 0; i <= rdel; i++) begin
      ready = (i == rdel);
      @(negedge clk);
      if (i == 0) begin
        cap_addr = req_addr; cap_we = req_we; cap_wstrb = req_wstrb; cap_wdata = req_wdata;
      end
      @(posedge clk); #1;
      scramble();
    end
    ready = 0;
    exp_valid = 0;
    if (is_ld(op)) begin
      for (int i = 0; i <= wdel; i++) begin
        resp_valid = (i == wdel);
        resp_data = (i == wdel) ? r : {$urandom, $urandom};
        @(posedge clk); #1;
        scramble();
      end
      resp_valid = 0;
    end
    exp_stall = 0; exp_lv = is_ld(op); exp_ld = mload(op, a, r); exp_rd = rd;
    ex_valid = 1; mem_op = 4'($urandom);
    @(negedge clk);
    cap_ld = load_data; cap_lv = load_valid;
    @(posedge clk); #1;
    ex_valid = 0; exp_lv = 0;
  endtask

  task automatic misaligned(input logic [3:0] op, input logic [63:0] a);
    ex_valid = 1; mem_op = op; addr = a;
    exp_valid = 0; exp_stall = 0; exp_lv = 0; exp_ml = is_ld(op); exp_ms = is_st(op);
    @(posedge clk); #1;
    ex_valid = 0; exp_ml = 0; exp_ms = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_load_data", load_data, 64'h0);
    chk("reset_rd_idx", 64'(rd_out), 64'h0);
    chk("reset_load_valid", 64'(load_valid), 64'h0);
    chk("reset_req_valid", 64'(req_valid), 64'h0);
    chk("reset_wstrb", 64'(req_wstrb), 64'h0);
    chk("reset_stall", 64'(stall), 64'h0);
    @(posedge clk); #1;
    chk_en = 1;
    chk("pin_model_lb", mload(4'd1, 64'h7, 64'h80AA_BBCC_DDEE_FF11), 64'hFFFF_FFFF_FFFF_FF80);
    chk("pin_model_lhu", mload(4'd6, 64'h2, 64'h0000_0000_8001_0000), 64'h0000_0000_0000_8001);

    xact(4'd3, 64'h8000_0004, 64'h0, 5'd7, 0, 0, 64'h1234_5678_9ABC_DEF0);
    chk("lw_req_addr", cap_addr, 64'h8000_0000);
    chk("lw_req_we", 64'(cap_we), 64'h0);
    chk("lw_req_wstrb", 64'(cap_wstrb), 64'h0);
    chk("lw_data", cap_ld, 64'h0000_0000_1234_5678);
    chk("lw_valid", 64'(cap_lv), 64'h1);
    xact(4'd1, 64'h8000_0007, 64'h0, 5'd3, 1, 2, 64'h80AA_BBCC_DDEE_FF11);
    chk("lb_data", cap_ld, 64'hFFFF_FFFF_FFFF_FF80);
    xact(4'd5, 64'h8000_0007, 64'h0, 5'd4, 0, 1, 64'h80AA_BBCC_DDEE_FF11);
    chk("lbu_data", cap_ld, 64'h0000_0000_0000_0080);
    xact(4'd9, 64'h8000_0006, 64'hBEEF, 5'd5, 3, 0, 64'h0);
    chk("sh_wstrb", 64'(cap_wstrb), 64'hC0);
    chk("sh_wdata", cap_wdata, 64'hBEEF_0000_0000_0000);
    chk("sh_we", 64'(cap_we), 64'h1);
    chk("sh_no_load_valid", 64'(cap_lv), 64'h0);
    misaligned(4'd3, 64'h8000_0002);
    misaligned(4'd11, 64'h8000_0004);

    // reset while waiting for load data; the late response must be dropped
    ex_valid = 1; mem_op = 4'd4; addr = 64'h8000_0010; rd_idx = 5'd9;
    exp_stall = 1;
    @(posedge clk); #1;
    ex_valid = 0; ready = 1;
    exp_valid = 1; exp_addr = 64'h8000_0010; exp_we = 0; exp_wstrb = 0;
    @(posedge clk); #1;
    ready = 0; exp_valid = 0; chk_en = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0; resp_valid = 1; resp_data = 64'hDEAD_BEEF_0000_1111;
    exp_stall = 0; exp_lv = 0; chk_en = 1;
    @(posedge clk); #1;
    resp_valid = 0;
    @(posedge clk); #1;
    xact(4'd4, 64'h8000_0018, 64'h0, 5'd10, 1, 1, 64'h0102_0304_0506_0708);
    chk("ld_after_reset", cap_ld, 64'h0102_0304_0506_0708);

    for (int t = 0; t < 60; t++) begin
      logic [3:0] op = 4'(1 + $urandom % 11);
      int nb = nbytes(op);
      logic [63:0] a = {$urandom, $urandom} & ~64'(nb - 1);
      if (nb > 1 && $urandom % 5 == 0) misaligned(op, a | 64'(1 + $urandom % (nb - 1)));
      else xact(op, a, {$urandom, $urandom}, 5'($urandom), $urandom % 3, $urandom % 3,
                {$urandom, $urandom});
    end
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
